// File: rtl/ifu_prefetch_swc.sv
`default_nettype none
// ============================================================================
// Module      : ifu_prefetch_swc
// Description : Instruction fetch unit. AHB-Lite read master that keeps a
//               DEPTH-entry prefetch queue filled with sequential words and
//               hands {pc, inst} to the decoder over a valid/ready handshake.
//               A pc_write redirect flushes the queue and kills in-flight
//               beats.
// Options     : `define IFU_FETCH_ERR_EN to record hresp errors in the queue
//               (fetch_err) and halt fetching until the next redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_prefetch_swc #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            hclk,
   input  logic            hrstn,
   input  logic            hready,
   input  logic            hresp,
   input  logic [XLEN-1:0] hrdata,
   input  logic            pc_write,
   input  logic [XLEN-1:0] pc_wdata,
   input  logic            dec_ready,
   output logic [XLEN-1:0] haddr,
   output logic [1:0]      htrans,
   output logic            hwrite,
   output logic [XLEN-1:0] hwdata,
   output logic [2:0]      hsize,
   output logic [2:0]      hburst,
   output logic [6:0]      hprot,
   output logic            hmastlock,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst_out,
   output logic [XLEN-1:0] pc,
   output logic            fetch_err,
   output logic            ifu_idle
);

   localparam int              c_AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int              c_CW         = $clog2(DEPTH + 1);
   localparam logic [c_CW:0]   c_DEPTH_W    = (c_CW + 1)'(DEPTH);
   localparam logic [XLEN-1:0] c_WORD       = XLEN'(4);
   localparam logic [XLEN-1:0] c_ALIGN_MASK = ~(XLEN'(3));
   localparam logic [1:0]      c_HTRANS_IDLE   = 2'b00;
   localparam logic [1:0]      c_HTRANS_NONSEQ = 2'b10;

   typedef enum logic [0:0] {
      S_FETCH = 1'b0,
      S_HALT  = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   // Address-phase and data-phase beat tracking. A beat is "live" while it
   // belongs to the current redirect epoch; redirects clear the live flags so
   // stale data completes on the bus but is never written.
   logic [XLEN-1:0] r_fetch_ptr;
   logic [XLEN-1:0] r_haddr;
   logic            r_ap_valid;
   logic            r_ap_live;
   logic            r_dp_valid;
   logic            r_dp_live;
   logic [XLEN-1:0] r_dp_addr;

   // Prefetch queue
   logic [XLEN-1:0] r_q_pc   [DEPTH];
   logic [XLEN-1:0] r_q_data [DEPTH];
   logic [DEPTH-1:0] r_q_err;
   logic [c_AW-1:0] r_rd_ptr;
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_CW-1:0] r_count;

   logic            w_inst_valid;
   logic            w_beat_err;
   logic            w_push;
   logic            w_push_err;
   logic            w_pop;
   logic            w_issue;
   logic [c_CW:0]   w_occ;
   logic [XLEN-1:0] w_push_data;
   logic [XLEN-1:0] w_redirect_pc;

`ifdef IFU_FETCH_ERR_EN
   assign w_beat_err = hresp;
`else
   // Error responses are not recorded in this build; the data is taken as-is.
   assign w_beat_err = 1'b0 & hresp;
`endif

   assign w_inst_valid  = (r_count != '0);
   assign w_redirect_pc = pc_wdata & c_ALIGN_MASK;

   // Issue / push / pop decisions and next fetch state
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = w_inst_valid & dec_ready & ~pc_write;
      w_push      = r_dp_valid & hready & r_dp_live & ~pc_write & (r_state == S_FETCH);
      w_push_err  = w_push & w_beat_err;
      w_push_data = w_beat_err ? '0 : hrdata;
      // Entries held plus beats still owed; a popped entry frees its slot now.
      w_occ       = {1'b0, r_count}
                  + {{c_CW{1'b0}}, r_ap_valid}
                  + {{c_CW{1'b0}}, r_dp_valid}
                  - {{c_CW{1'b0}}, w_pop};
      w_issue     = (r_state == S_FETCH) & hready & ~pc_write & ~w_push_err
                  & (w_occ < c_DEPTH_W);
      if (pc_write) begin
         w_state_nxt = S_FETCH;
      end
`ifdef IFU_FETCH_ERR_EN
      else if (w_push_err) begin
         w_state_nxt = S_HALT;
      end
`endif
   end

   // Fetch state register
   always_ff @(posedge hclk or negedge hrstn) begin
      if (!hrstn) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // AHB address/data pipeline; nothing moves while hready is low
   always_ff @(posedge hclk or negedge hrstn) begin
      if (!hrstn) begin
         r_fetch_ptr <= RESET_PC;
         r_haddr     <= RESET_PC;
         r_ap_valid  <= 1'b0;
         r_ap_live   <= 1'b0;
         r_dp_valid  <= 1'b0;
         r_dp_live   <= 1'b0;
         r_dp_addr   <= '0;
      end else begin
         if (hready) begin
            r_dp_valid <= r_ap_valid;
            r_dp_addr  <= r_haddr;
            r_dp_live  <= r_ap_live & ~pc_write;
            r_ap_valid <= w_issue;
            if (w_issue) begin
               r_haddr   <= r_fetch_ptr;
               r_ap_live <= 1'b1;
            end
         end else if (pc_write) begin
            // Held address phase cannot be withdrawn; just mark it stale.
            r_ap_live <= 1'b0;
            r_dp_live <= 1'b0;
         end
         if (pc_write) begin
            r_fetch_ptr <= w_redirect_pc;
         end else if (w_issue) begin
            r_fetch_ptr <= r_fetch_ptr + c_WORD;
         end
      end
   end

   // Prefetch queue storage and occupancy; redirect empties it
   always_ff @(posedge hclk or negedge hrstn) begin
      if (!hrstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_q_pc[i]   <= RESET_PC;
            r_q_data[i] <= '0;
         end
         r_q_err  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (pc_write) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_q_pc[r_wr_ptr]   <= r_dp_addr;
            r_q_data[r_wr_ptr] <= w_push_data;
            r_q_err[r_wr_ptr]  <= w_beat_err;
            r_wr_ptr           <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign haddr      = r_haddr;
   assign htrans     = r_ap_valid ? c_HTRANS_NONSEQ : c_HTRANS_IDLE;
   assign hwrite     = 1'b0;
   assign hwdata     = '0;
   assign hsize      = 3'b010;
   assign hburst     = 3'b000;
   assign hprot      = 7'b000_0010;
   assign hmastlock  = 1'b0;

   assign inst_valid = w_inst_valid;
   assign inst_out   = w_inst_valid ? r_q_data[r_rd_ptr] : '0;
   assign pc         = r_q_pc[r_rd_ptr];
   assign fetch_err  = w_inst_valid & r_q_err[r_rd_ptr];
   assign ifu_idle   = ~w_inst_valid & ~r_ap_valid & ~r_dp_valid;

endmodule
`default_nettype wire
